host_mbox: RTL and testbench

HOST_MBOX -- requirements
Module: host_mbox

---
 rtl/arvi_mmio_pkg.sv | 17 +
 rtl/sync_fifo.sv | 37 +++
 rtl/host_mbox.sv | 83 ++++++++
 tb/tb_host_mbox.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/arvi_mmio_pkg.sv
// arvi_mmio_pkg: mailbox register map, STATUS bit layout, FSM states and a byte-lane merge helper.
package arvi_mmio_pkg;
    localparam logic [3:0] OFS_TOHOST   = 4'h0;
    localparam logic [3:0] OFS_FROMHOST = 4'h4;
    localparam logic [3:0] OFS_TXDATA   = 4'h8;
    localparam logic [3:0] OFS_STATUS   = 4'hC;
    localparam int STAT_HALT    = 31;
    localparam int STAT_FULL    = 14;
    localparam int STAT_EMPTY   = 13;
    localparam int STAT_COUNT_W = 7;
    typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAIT} mbox_state_e;
    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data, input logic [3:0] b_en);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = b_en[i] ? data[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; pointers carry one extra wrap bit so full and empty differ.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    // a pop frees the slot this push needs, so full does not block it
    assign do_push = push && (!full || do_pop);
    assign count   = wptr - rptr;
    assign empty   = wptr == rptr;
    assign full    = count == (AW+1)'(DEPTH);
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
        end
    always_ff @(posedge clk)
        if (do_push) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/host_mbox.sv
// host_mbox: 16-byte MMIO mailbox with TOHOST/halt, FROMHOST scratch, STATUS and a TX byte stream.
module host_mbox
    import arvi_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_1000,
    parameter int          TX_DEPTH  = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cs,
    input  logic        i_wr_en,
    input  logic [3:0]  i_b_en,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_addr,
    output logic        o_ack,
    output logic [31:0] o_rd_data,
    output logic [31:0] o_to_host,
    output logic        o_halt,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready
);
    localparam int AW = $clog2(TX_DEPTH);
    mbox_state_e state, state_n;
    logic [31:0] offset, fromhost, fromhost_n, to_host_n, rd_data_n, status;
    logic [3:0] ofs;
    logic [AW:0] count;
    logic full, empty, push, pop, hit, sel_tx, stall, fire, wr_th, halt_n;
    assign offset     = i_addr - BASE_ADDR;
    assign hit        = i_cs && offset < 32'd16;
    assign ofs        = {offset[3:2], 2'b00};
    assign pop        = !empty && i_tx_ready;
    assign sel_tx     = i_wr_en && ofs == OFS_TXDATA && i_b_en[0];
    assign stall      = sel_tx && full && !pop;
    assign o_ack      = state == ST_ACK;
    assign o_tx_valid = !empty;
    always_comb begin
        status = '0;
        status[STAT_HALT] = o_halt;
        status[STAT_FULL] = full;
        status[STAT_EMPTY] = empty;
        status[STAT_COUNT_W-1:0] = STAT_COUNT_W'(count);
    end
    // IDLE and WAIT both retry the held request; ACK always returns to IDLE
    always_comb begin
        state_n    = state == ST_ACK || !hit ? ST_IDLE : stall ? ST_WAIT : ST_ACK;
        fire       = state != ST_ACK && hit && !stall;
        push       = fire && sel_tx;
        wr_th      = fire && i_wr_en && ofs == OFS_TOHOST;
        to_host_n  = wr_th ? merge_bytes(o_to_host, i_wr_data, i_b_en) : o_to_host;
        halt_n     = o_halt || (wr_th && to_host_n[0]);
        fromhost_n = fire && i_wr_en && ofs == OFS_FROMHOST ? merge_bytes(fromhost, i_wr_data, i_b_en) : fromhost;
        rd_data_n  = !fire || i_wr_en ? '0 :
                     ofs == OFS_TOHOST ? o_to_host :
                     ofs == OFS_FROMHOST ? fromhost :
                     ofs == OFS_STATUS ? status : '0;
    end
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state     <= ST_IDLE;
            o_rd_data <= '0;
            o_to_host <= '0;
            fromhost  <= '0;
            o_halt    <= 1'b0;
        end else begin
            state     <= state_n;
            o_rd_data <= rd_data_n;
            o_to_host <= to_host_n;
            fromhost  <= fromhost_n;
            o_halt    <= halt_n;
        end
    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (pop),
        .din   (i_wr_data[7:0]),
        .dout  (o_tx_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );
endmodule

// File: tb/tb_host_mbox.sv
// tb_host_mbox: directed register-map scenarios plus randomized traffic checked every cycle
// against a transaction-level model (register values and a byte queue).
module tb_host_mbox;
    localparam logic [31:0] BASE = 32'h8000_1000;
    localparam int DEPTH = 8;
    logic i_clk = 0, i_rst = 1, i_cs = 0, i_wr_en = 0;
    logic [3:0] i_b_en = 0;
    logic [31:0] i_wr_data = 0, i_addr = 0;
    logic o_ack, o_halt, o_tx_valid, i_tx_ready;
    logic [31:0] o_rd_data, o_to_host;
    logic [7:0] o_tx_data;
    logic rnd_mode = 0, rnd_bit = 0, ready_dir = 0;
    int checks = 0, errors = 0;

    assign i_tx_ready = rnd_mode ? rnd_bit : ready_dir;
    always #5 i_clk = ~i_clk;
    always @(negedge i_clk) rnd_bit <= ($urandom % 4) == 0;

    host_mbox #(.BASE_ADDR(BASE), .TX_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cs(i_cs), .i_wr_en(i_wr_en), .i_b_en(i_b_en),
        .i_wr_data(i_wr_data), .i_addr(i_addr), .o_ack(o_ack), .o_rd_data(o_rd_data),
        .o_to_host(o_to_host), .o_halt(o_halt), .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
        .i_tx_ready(i_tx_ready)
    );

    // transaction-level model: one access per ack, then a mandatory idle cycle
    logic [31:0] m_to_host = 0, m_from = 0, m_rd = 0, m_off;
    logic m_halt = 0, m_ack = 0, m_pop, m_push;
    logic [7:0] m_q[$];

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] v = old;
        for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
        return v;
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_to_host = 0; m_from = 0; m_rd = 0; m_halt = 0; m_ack = 0;
            m_q.delete();
        end else begin
            m_off  = i_addr - BASE;
            m_pop  = m_q.size() != 0 && i_tx_ready;
            m_push = 0;
            m_rd   = 0;
            if (m_ack) m_ack = 0;
            else if (i_cs && m_off < 16 &&
                     !(i_wr_en && m_off[3:2] == 2 && i_b_en[0] && m_q.size() == DEPTH && !m_pop)) begin
                m_ack = 1;
                if (i_wr_en) begin
                    if (m_off[3:2] == 0) begin
                        m_to_host = lanes(m_to_host, i_wr_data, i_b_en);
                        m_halt = m_halt | m_to_host[0];
                    end
                    if (m_off[3:2] == 1) m_from = lanes(m_from, i_wr_data, i_b_en);
                    if (m_off[3:2] == 2) m_push = i_b_en[0];
                end else begin
                    if (m_off[3:2] == 0) m_rd = m_to_host;
                    if (m_off[3:2] == 1) m_rd = m_from;
                    if (m_off[3:2] == 3)
                        m_rd = {m_halt, 16'b0, m_q.size() == DEPTH, m_q.size() == 0, 6'b0, 7'(m_q.size())};
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) m_q.push_back(i_wr_data[7:0]);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // every cycle advance goes through here so the model is compared on each cycle
    task automatic tick();
        logic v;
        @(negedge i_clk);
        if (!i_rst) begin
            v = m_q.size() != 0;
            chk("ack", 32'(o_ack), 32'(m_ack));
            chk("rd_data", o_rd_data, m_rd);
            chk("to_host", o_to_host, m_to_host);
            chk("halt", 32'(o_halt), 32'(m_halt));
            chk("tx_valid", 32'(o_tx_valid), 32'(v));
            chk("tx_data", 32'(o_tx_data), v ? 32'(m_q[0]) : 32'h0);
        end
    endtask

    task automatic access(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
        i_cs = 1; i_wr_en = wr; i_addr = addr; i_b_en = be; i_wr_data = wd;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!o_ack && lat < 200);
        chk("ack_within_budget", 32'(o_ack), 32'h1);
        rd = o_rd_data;
        i_cs = 0;
    endtask

    task automatic do_reset();
        i_rst = 1; i_cs = 0;
        tick();
        tick();
        i_rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [31:0] rd;
    int lat, k;
    logic wr;
    initial begin
        repeat (3) tick();
        i_rst = 0;
        tick();
        chk("reset_ack", 32'(o_ack), 0);
        chk("reset_to_host", o_to_host, 0);
        chk("reset_halt", 32'(o_halt), 0);
        chk("reset_tx_valid", 32'(o_tx_valid), 0);
        access(0, BASE + 12, 4'hF, 0, rd, lat);
        chk("reset_status", rd, 32'h0000_2000);

        do_reset();
        access(1, BASE, 4'hF, 32'h0000_0001, rd, lat);
        chk("tohost_latency", 32'(lat), 1);
        chk("tohost_value", o_to_host, 32'h1);
        chk("tohost_halt", 32'(o_halt), 1);

        do_reset();
        access(1, BASE + 4, 4'b0101, 32'hAABB_CCDD, rd, lat);
        access(0, BASE + 4, 4'hF, 0, rd, lat);
        chk("fromhost_lanes", rd, 32'h00BB_00DD);
        access(0, BASE + 8, 4'hF, 0, rd, lat);
        chk("txdata_read_zero", rd, 0);

        i_cs = 1; i_wr_en = 0; i_addr = BASE + 32'h10; i_b_en = 4'hF;
        repeat (10) begin
            tick();
            chk("out_of_window_no_ack", 32'(o_ack), 0);
        end
        i_cs = 0;

        do_reset();
        ready_dir = 0;
        for (int i = 0; i < 8; i++) access(1, BASE + 8, 4'hF, 32'h10 + i, rd, lat);
        access(0, BASE + 12, 4'hF, 0, rd, lat);
        chk("status_full", rd, 32'h0000_4008);
        i_cs = 1; i_wr_en = 1; i_addr = BASE + 8; i_b_en = 4'hF; i_wr_data = 32'h18;
        repeat (4) begin
            tick();
            chk("full_stall_no_ack", 32'(o_ack), 0);
        end
        chk("stall_head_byte0", 32'(o_tx_data), 32'h10);
        ready_dir = 1;
        tick();
        chk("stall_release_ack", 32'(o_ack), 1);
        chk("head_after_pop", 32'(o_tx_data), 32'h11);
        ready_dir = 0; i_cs = 0;
        access(0, BASE + 12, 4'hF, 0, rd, lat);
        chk("status_still_full", rd, 32'h0000_4008);

        do_reset();
        ready_dir = 1;
        access(1, BASE + 8, 4'h1, 32'h48, rd, lat);
        chk("stream_H_valid", 32'(o_tx_valid), 1);
        chk("stream_H", 32'(o_tx_data), 32'h48);
        access(1, BASE + 8, 4'h1, 32'h69, rd, lat);
        chk("stream_i", 32'(o_tx_data), 32'h69);
        tick();
        chk("stream_drained", 32'(o_tx_valid), 0);

        do_reset();
        ready_dir = 0;
        access(1, BASE + 8, 4'hF, 32'h55, rd, lat);
        i_cs = 1; i_wr_en = 1; i_addr = BASE; i_b_en = 4'hF; i_wr_data = 32'h1;
        tick();
        tick();
        chk("pre_reset_ack", 32'(o_ack), 1);
        chk("pre_reset_halt", 32'(o_halt), 1);
        i_rst = 1;
        #1;
        chk("async_rst_ack", 32'(o_ack), 0);
        chk("async_rst_rd", o_rd_data, 0);
        chk("async_rst_to_host", o_to_host, 0);
        chk("async_rst_halt", 32'(o_halt), 0);
        chk("async_rst_tx_valid", 32'(o_tx_valid), 0);
        chk("async_rst_tx_data", 32'(o_tx_data), 0);
        i_cs = 0;
        tick();
        i_rst = 0;
        tick();

        rnd_mode = 1;
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            if (k == 9) begin
                i_cs = 1; i_wr_en = 1'($urandom); i_b_en = 4'($urandom); i_wr_data = $urandom;
                i_addr = ($urandom % 2) ? BASE + 32'h10 + 4 * $urandom_range(0, 3) : BASE - 4;
                repeat (3) tick();
                i_cs = 0;
            end else begin
                wr = k < 3 || ($urandom % 2) == 1;
                access(wr, BASE + (k < 3 ? 8 : 4 * $urandom_range(0, 3)), 4'($urandom), $urandom, rd, lat);
            end
            if ($urandom % 4 == 0) tick();
        end
        rnd_mode = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
